// File: rtl/fifo_ctrl_pkg.sv
// Shared types and pointer/address helpers for the producer and consumer FIFO controllers.
package fifo_ctrl_pkg;

  localparam int unsigned MSHRID_W = 4;

  typedef logic [31:0]         ptr_t;
  typedef logic [63:0]         addr_t;
  typedef logic [31:0]         size_t;
  typedef logic [31:0]         length_t;
  typedef logic [63:0]         data_t;
  typedef logic [127:0]        cacheline_t;
  typedef logic [MSHRID_W-1:0] mshrid_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REQ,
    ST_WAIT_ACK
  } push_state_e;

  typedef struct packed {
    logic       valid;
    addr_t      addr;
    cacheline_t data;
    size_t      size;
    mshrid_t    mshrid;
  } st_req_o_t;

  typedef struct packed {
    logic ready;
  } st_req_i_t;

  typedef struct packed {
    logic    valid;
    mshrid_t mshrid;
  } st_resp_i_t;

  function automatic ptr_t inc_ptr_one(input ptr_t ptr, input length_t len);
    return (ptr == len - 32'd1) ? '0 : ptr + 32'd1;
  endfunction

  // The address wraps back to base together with the pointer.
  function automatic addr_t inc_addr(input addr_t addr, input addr_t base, input size_t size,
                                     input ptr_t ptr, input length_t len);
    return (ptr == len - 32'd1) ? base : addr + {32'b0, size};
  endfunction

  function automatic logic fifo_is_full(input ptr_t head, input ptr_t tail, input length_t len);
    return inc_ptr_one(head, len) == tail;
  endfunction

endpackage

// File: rtl/fifo_push_pack.sv
// Element slots and store data/size assembly for fifo_push_ctrl.
// Slot 1 and the pair timeout counter exist only when FIFO_PUSH_PAIR_EN is defined.
module fifo_push_pack
  import fifo_ctrl_pkg::*;
`ifdef FIFO_PUSH_PAIR_EN
#(
  parameter int unsigned PAIR_TIMEOUT = 16
)
`endif
(
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef FIFO_PUSH_PAIR_EN
  input  logic       flush_i,
  input  logic       pair_ok_i,
`endif
  input  logic       accept_i,
  input  data_t      in_data_i,
  input  size_t      elem_size_i,
  output logic       fire_o,
  output logic       pair_o,
  output cacheline_t data_o,
  output size_t      size_o
);

  cacheline_t data_q;
  size_t      size_q;

  assign data_o = data_q;
  assign size_o = size_q;

`ifdef FIFO_PUSH_PAIR_EN
  localparam int unsigned TIMER_W = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT) : 1;

  logic               has_one;
  logic               pair_q;
  logic [TIMER_W-1:0] timer;
  logic               timeout;

  assign pair_o  = pair_q;
  assign timeout = has_one && (timer == TIMER_W'(PAIR_TIMEOUT - 1));

  always_comb begin
    fire_o = 1'b0;
    if (accept_i)
      fire_o = has_one || !pair_ok_i;
    else if (timeout)
      fire_o = 1'b1;
  end

  // A first element that could start a pair parks in slot 0 until a partner arrives or time runs out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      size_q  <= '0;
      pair_q  <= 1'b0;
      has_one <= 1'b0;
      timer   <= '0;
    end else if (flush_i) begin
      has_one <= 1'b0;
      timer   <= '0;
    end else if (accept_i && !has_one) begin
      data_q <= {64'b0, in_data_i};
      timer  <= '0;
      if (pair_ok_i) begin
        has_one <= 1'b1;
      end else begin
        size_q <= elem_size_i;
        pair_q <= 1'b0;
      end
    end else if (accept_i) begin
      data_q[127:64] <= in_data_i;
      size_q         <= size_t'(elem_size_i << 1);
      pair_q         <= 1'b1;
      has_one        <= 1'b0;
    end else if (timeout) begin
      size_q  <= elem_size_i;
      pair_q  <= 1'b0;
      has_one <= 1'b0;
    end else if (has_one) begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign fire_o = accept_i;
  assign pair_o = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      size_q <= '0;
    end else if (accept_i) begin
      data_q <= {64'b0, in_data_i};
      size_q <= elem_size_i;
    end
  end
`endif

endmodule

// File: rtl/fifo_push_ctrl.sv
// Producer-side FIFO controller: stores stream elements to a memory ring and publishes head after ack.
// Define FIFO_PUSH_PAIR_EN to enable 16-byte paired stores.
module fifo_push_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned PAIR_TIMEOUT = 16,
  parameter mshrid_t     MSHRID       = '0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_valid_i,
  input  addr_t      cfg_base_i,
  input  size_t      cfg_size_i,
  input  length_t    cfg_len_i,
  input  logic       cfg_clear_i,
  input  ptr_t       tail_i,
  input  logic       in_valid_i,
  input  data_t      in_data_i,
  output logic       in_ready_o,
  output logic       st_req_valid_o,
  output addr_t      st_req_addr_o,
  output cacheline_t st_req_data_o,
  output size_t      st_req_size_o,
  output mshrid_t    st_req_mshrid_o,
  input  logic       st_req_ready_i,
  input  logic       st_resp_valid_i,
  input  mshrid_t    st_resp_mshrid_i,
  output ptr_t       head_o,
  output logic       busy_o
);

  push_state_e state;
  addr_t       base_q, addr_q;
  size_t       size_q;
  length_t     len_q;
  ptr_t        head_q;
  logic        req_valid_q, busy_q, clear_pend_q;

  st_req_o_t   st_req;
  st_req_i_t   st_req_in;
  st_resp_i_t  st_resp;

  logic        accept, ack_match;
  logic        pack_fire, pack_pair;
  cacheline_t  pack_data;
  size_t       pack_size;
  ptr_t        head_p1, head_p2;
  addr_t       addr_p1, addr_p2;

  always_comb begin
    st_req.valid  = req_valid_q;
    st_req.addr   = addr_q;
    st_req.data   = pack_data;
    st_req.size   = pack_size;
    st_req.mshrid = MSHRID;
    st_req_in.ready = st_req_ready_i;
    st_resp.valid   = st_resp_valid_i;
    st_resp.mshrid  = st_resp_mshrid_i;
  end

  assign st_req_valid_o  = st_req.valid;
  assign st_req_addr_o   = st_req.addr;
  assign st_req_data_o   = st_req.data;
  assign st_req_size_o   = st_req.size;
  assign st_req_mshrid_o = st_req.mshrid;
  assign head_o          = head_q;
  assign busy_o          = busy_q;

  assign in_ready_o = (state == ST_COLLECT) && !fifo_is_full(head_q, tail_i, len_q);
  assign accept     = in_valid_i && in_ready_o;
  assign ack_match  = st_resp.valid && (st_resp.mshrid == MSHRID);

  always_comb begin
    head_p1 = inc_ptr_one(head_q, len_q);
    head_p2 = inc_ptr_one(head_p1, len_q);
    addr_p1 = inc_addr(addr_q, base_q, size_q, head_q, len_q);
    addr_p2 = inc_addr(addr_p1, base_q, size_q, head_p1, len_q);
  end

`ifdef FIFO_PUSH_PAIR_EN
  logic pair_ok;
  assign pair_ok = (size_q == 32'd8) && (base_q[3:0] == 4'd0) && !head_q[0] &&
                   (head_q != len_q - 32'd1) && (head_p2 != tail_i);
`endif

  fifo_push_pack
`ifdef FIFO_PUSH_PAIR_EN
    #(.PAIR_TIMEOUT(PAIR_TIMEOUT))
`endif
  u_pack (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef FIFO_PUSH_PAIR_EN
    .flush_i     ((state == ST_COLLECT) && cfg_clear_i),
    .pair_ok_i   (pair_ok),
`endif
    .accept_i    (accept && !cfg_clear_i),
    .in_data_i   (in_data_i),
    .elem_size_i (size_q),
    .fire_o      (pack_fire),
    .pair_o      (pack_pair),
    .data_o      (pack_data),
    .size_o      (pack_size)
  );

  // A clear seen while a store is in flight is held until the ack so the memory transaction completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      len_q        <= '0;
      head_q       <= '0;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            base_q <= cfg_base_i;
            addr_q <= cfg_base_i;
            size_q <= cfg_size_i;
            len_q  <= cfg_len_i;
            head_q <= '0;
            state  <= ST_COLLECT;
          end else if (cfg_clear_i) begin
            head_q <= '0;
          end
        end
        ST_COLLECT: begin
          if (cfg_clear_i) begin
            head_q <= '0;
            state  <= ST_IDLE;
          end else if (pack_fire) begin
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cfg_clear_i)
            clear_pend_q <= 1'b1;
          if (st_req_in.ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (cfg_clear_i)
            clear_pend_q <= 1'b1;
          if (ack_match) begin
            busy_q       <= 1'b0;
            clear_pend_q <= 1'b0;
            if (clear_pend_q || cfg_clear_i) begin
              head_q <= '0;
              state  <= ST_IDLE;
            end else begin
              head_q <= pack_pair ? head_p2 : head_p1;
              addr_q <= pack_pair ? addr_p2 : addr_p1;
              state  <= ST_COLLECT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
